calibration_multi: RTL and testbench

- Parametrised calibration block for the tracking DMX controller. Next generation of the hard-coded single-light calibration.
- Holds the room extent and a height ratio. Height is adjustable from push buttons with press / hold / auto-repeat conditioning.
- Stores position and DMX pan/tilt addresses for N_LIGHTS fixtures in a writable table. Downstream pan/tilt math reads fixtures by index.
- Sits between the board buttons / config source and the per-light angle computation.

---
 rtl/calibration_multi.sv | 262 ++++++++++++++++++++++++++
 tb/tb_calibration_multi.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calibration_multi.sv
`default_nettype none
// ============================================================================
// Module      : calibration_multi
// Description : Room-extent / height-ratio calibration with push-button
//               press, hold and auto-repeat conditioning, plus a writable
//               table of fixture positions and DMX pan/tilt addresses.
// Revision    : 1.0 - initial multi-fixture release
// ============================================================================
module calibration_multi #(
    parameter int N_LIGHTS      = 4,
    parameter int IDX_W         = 2,
    parameter int X_PIXELS      = 1024,
    parameter int Y_PIXELS      = 768,
    parameter int RATIO_INIT    = 400,
    parameter int RATIO_MIN     = 0,
    parameter int RATIO_MAX     = 1023,
    parameter int HOLD_CYCLES   = 262144,
    parameter int REPEAT_CYCLES = 65536
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             height_cal_up,
    input  logic             height_cal_down,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [10:0]      cfg_x,
    input  logic [9:0]       cfg_y,
    input  logic [8:0]       cfg_pan,
    input  logic [8:0]       cfg_tilt,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [10:0]      x_real_world,
    output logic [9:0]       y_real_world,
    output logic [11:0]      z_real_world,
    output logic [9:0]       ratio_n,
    output logic [10:0]      x_light,
    output logic [9:0]       y_light,
    output logic [8:0]       pan_addr,
    output logic [8:0]       tilt_addr,
    output logic             step_pulse
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int          c_AW          = (N_LIGHTS > 1) ? $clog2(N_LIGHTS) : 1;
    localparam logic [9:0]  c_RATIO_INIT  = 10'(RATIO_INIT);
    localparam logic [9:0]  c_RATIO_MIN   = 10'(RATIO_MIN);
    localparam logic [9:0]  c_RATIO_MAX   = 10'(RATIO_MAX);
    localparam logic [20:0] c_X_W         = 21'(X_PIXELS);
    localparam logic [11:0] c_Z_INIT      = 12'((X_PIXELS * RATIO_INIT) >> 9);
    localparam logic [19:0] c_HOLD_LAST   = 20'(HOLD_CYCLES - 1);
    localparam logic [19:0] c_REPEAT_LAST = 20'(REPEAT_CYCLES - 1);

    // Fixture reset defaults; pan/tilt addresses are derived from the index
    localparam logic [10:0] c_X_DEF = 11'd380;
    localparam logic [9:0]  c_Y_DEF = 10'd350;

    // ------------------------------------------------------------------
    // Button conditioning FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        dir_up_q, dir_up_d;   // latched direction: 1 = up, 0 = down
    logic [19:0] cnt_q, cnt_d;
    logic        step_up, step_dn;

    logic w_dir_up;
    logic w_dir_dn;
    logic w_dir_held;

    // Both buttons together is treated the same as no button at all
    assign w_dir_up   = height_cal_up & ~height_cal_down;
    assign w_dir_dn   = height_cal_down & ~height_cal_up;
    assign w_dir_held = dir_up_q ? w_dir_up : w_dir_dn;

    // FSM state, latched direction and dwell counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            dir_up_q <= 1'b0;
            cnt_q    <= 20'd0;
        end else begin
            state_q  <= state_d;
            dir_up_q <= dir_up_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic and step requests; counter restarts on every state entry
    always_comb begin
        state_d  = state_q;
        dir_up_d = dir_up_q;
        cnt_d    = cnt_q;
        step_up  = 1'b0;
        step_dn  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_dir_up || w_dir_dn) begin
                    step_up  = w_dir_up;
                    step_dn  = w_dir_dn;
                    dir_up_d = w_dir_up;
                    state_d  = ST_HOLD;
                    cnt_d    = 20'd0;
                end
            end
            ST_HOLD: begin
                if (!w_dir_held) begin
                    // Release, both pressed, or a swap: abandon without a step
                    state_d = ST_IDLE;
                    cnt_d   = 20'd0;
                end else if (cnt_q == c_HOLD_LAST) begin
                    step_up = dir_up_q;
                    step_dn = ~dir_up_q;
                    state_d = ST_REPEAT;
                    cnt_d   = 20'd0;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            ST_REPEAT: begin
                if (!w_dir_held) begin
                    state_d = ST_IDLE;
                    cnt_d   = 20'd0;
                end else if (cnt_q == c_REPEAT_LAST) begin
                    step_up = dir_up_q;
                    step_dn = ~dir_up_q;
                    cnt_d   = 20'd0;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 20'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Ratio stepping with saturation and derived height
    // ------------------------------------------------------------------
    logic [9:0]  ratio_q, ratio_d;
    logic        pulse_q, pulse_d;
    logic [11:0] z_q;
    logic [20:0] w_prod;
    logic [11:0] w_z;

    // A step at a limit is swallowed: no value change and no pulse
    always_comb begin
        ratio_d = ratio_q;
        pulse_d = 1'b0;
        if (step_up && (ratio_q < c_RATIO_MAX)) begin
            ratio_d = ratio_q + 10'd1;
            pulse_d = 1'b1;
        end else if (step_dn && (ratio_q > c_RATIO_MIN)) begin
            ratio_d = ratio_q - 10'd1;
            pulse_d = 1'b1;
        end
    end

    // z = X * ratio / 512, formed from the already-registered ratio
    assign w_prod = c_X_W * {11'd0, ratio_q};
    assign w_z    = 12'(w_prod >> 9);

    // Ratio, its change pulse, and the height that trails it by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            ratio_q <= c_RATIO_INIT;
            pulse_q <= 1'b0;
            z_q     <= c_Z_INIT;
        end else begin
            ratio_q <= ratio_d;
            pulse_q <= pulse_d;
            z_q     <= w_z;
        end
    end

    // ------------------------------------------------------------------
    // Fixture table
    // ------------------------------------------------------------------
    logic [10:0] tab_x_q    [N_LIGHTS];
    logic [9:0]  tab_y_q    [N_LIGHTS];
    logic [8:0]  tab_pan_q  [N_LIGHTS];
    logic [8:0]  tab_tilt_q [N_LIGHTS];

    logic [31:0]     w_cfg_idx_ext;
    logic [31:0]     w_rd_idx_ext;
    logic            w_wr_ok;
    logic            w_rd_ok;
    logic [c_AW-1:0] w_wr_sel;
    logic [c_AW-1:0] w_rd_sel;

    // Out-of-range indices are detected on the full index before it is narrowed
    assign w_cfg_idx_ext = 32'(cfg_idx);
    assign w_rd_idx_ext  = 32'(rd_idx);
    assign w_wr_ok       = cfg_we && (w_cfg_idx_ext < 32'(N_LIGHTS));
    assign w_rd_ok       = (w_rd_idx_ext < 32'(N_LIGHTS));
    assign w_wr_sel      = cfg_idx[c_AW-1:0];
    assign w_rd_sel      = rd_idx[c_AW-1:0];

    // Table storage with per-index default addresses
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_LIGHTS; i++) begin
                tab_x_q[i]    <= c_X_DEF;
                tab_y_q[i]    <= c_Y_DEF;
                tab_pan_q[i]  <= 9'(2 * i + 1);
                tab_tilt_q[i] <= 9'(2 * i + 2);
            end
        end else if (w_wr_ok) begin
            tab_x_q[w_wr_sel]    <= cfg_x;
            tab_y_q[w_wr_sel]    <= cfg_y;
            tab_pan_q[w_wr_sel]  <= cfg_pan;
            tab_tilt_q[w_wr_sel] <= cfg_tilt;
        end
    end

    logic [10:0] x_light_q;
    logic [9:0]  y_light_q;
    logic [8:0]  pan_q;
    logic [8:0]  tilt_q;

    // Registered read port; a same-cycle write to the same entry is not bypassed
    always_ff @(posedge clk) begin
        if (reset) begin
            x_light_q <= c_X_DEF;
            y_light_q <= c_Y_DEF;
            pan_q     <= 9'd1;
            tilt_q    <= 9'd2;
        end else if (w_rd_ok) begin
            x_light_q <= tab_x_q[w_rd_sel];
            y_light_q <= tab_y_q[w_rd_sel];
            pan_q     <= tab_pan_q[w_rd_sel];
            tilt_q    <= tab_tilt_q[w_rd_sel];
        end else begin
            x_light_q <= 11'd0;
            y_light_q <= 10'd0;
            pan_q     <= 9'd0;
            tilt_q    <= 9'd0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign x_real_world = 11'(X_PIXELS);
    assign y_real_world = 10'(Y_PIXELS);
    assign z_real_world = z_q;
    assign ratio_n      = ratio_q;
    assign step_pulse   = pulse_q;
    assign x_light      = x_light_q;
    assign y_light      = y_light_q;
    assign pan_addr     = pan_q;
    assign tilt_addr    = tilt_q;

endmodule
`default_nettype wire

// File: tb/tb_calibration_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_calibration_multi
// Description : Self-checking bench for calibration_multi: a press-duration
//               reference model compared every cycle, plus literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calibration_multi;

    localparam int N   = 4;
    localparam int IW  = 3;
    localparam int XP  = 1024;
    localparam int YP  = 768;
    localparam int RI  = 400;
    localparam int RMN = 0;
    localparam int RMX = 1023;
    localparam int H   = 8;
    localparam int R   = 4;

    logic          clk;
    logic          reset;
    logic          up;
    logic          dn;
    logic          we;
    logic [IW-1:0] cidx;
    logic [10:0]   cx;
    logic [9:0]    cy;
    logic [8:0]    cpan;
    logic [8:0]    ctilt;
    logic [IW-1:0] ridx;
    logic [10:0]   xrw;
    logic [9:0]    yrw;
    logic [11:0]   zrw;
    logic [9:0]    ratio;
    logic [10:0]   xl;
    logic [9:0]    yl;
    logic [8:0]    pan;
    logic [8:0]    tilt;
    logic          pulse;

    calibration_multi #(
        .N_LIGHTS(N), .IDX_W(IW), .X_PIXELS(XP), .Y_PIXELS(YP),
        .RATIO_INIT(RI), .RATIO_MIN(RMN), .RATIO_MAX(RMX),
        .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
    ) dut (
        .clk(clk), .reset(reset),
        .height_cal_up(up), .height_cal_down(dn),
        .cfg_we(we), .cfg_idx(cidx), .cfg_x(cx), .cfg_y(cy),
        .cfg_pan(cpan), .cfg_tilt(ctilt), .rd_idx(ridx),
        .x_real_world(xrw), .y_real_world(yrw), .z_real_world(zrw),
        .ratio_n(ratio), .x_light(xl), .y_light(yl),
        .pan_addr(pan), .tilt_addr(tilt), .step_pulse(pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: steps happen at press-age 0, H, H+R, H+2R, ...
    // ------------------------------------------------------------------
    int m_ratio, m_z, m_pulse;
    int m_x, m_y, m_pan, m_tilt;
    int tx[N], ty[N], tp[N], tt[N];
    int active;     // +1 up, -1 down, 0 no press in progress
    int age;        // cycles since the current press began
    bit valid = 0;

    always @(posedge clk) begin
        int dir, step;
        dir = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
        if (reset) begin
            m_ratio = RI;
            m_z     = (XP * RI) / 512;
            m_pulse = 0;
            active  = 0;
            age     = 0;
            for (int i = 0; i < N; i++) begin
                tx[i] = 380; ty[i] = 350; tp[i] = 2 * i + 1; tt[i] = 2 * i + 2;
            end
            m_x = 380; m_y = 350; m_pan = 1; m_tilt = 2;
            valid = 1;
        end else begin
            m_z = ((XP * m_ratio) / 512) % 4096;
            if (int'(ridx) < N) begin
                m_x = tx[ridx]; m_y = ty[ridx]; m_pan = tp[ridx]; m_tilt = tt[ridx];
            end else begin
                m_x = 0; m_y = 0; m_pan = 0; m_tilt = 0;
            end
            if (we && int'(cidx) < N) begin
                tx[cidx] = int'(cx); ty[cidx] = int'(cy);
                tp[cidx] = int'(cpan); tt[cidx] = int'(ctilt);
            end
            step = 0;
            if (active != 0) begin
                if (dir == active) begin
                    age++;
                    if (age == H || (age > H && ((age - H) % R) == 0)) step = active;
                end else begin
                    active = 0;
                end
            end else if (dir != 0) begin
                active = dir;
                age    = 0;
                step   = dir;
            end
            m_pulse = 0;
            if (step == 1 && m_ratio < RMX) begin
                m_ratio++; m_pulse = 1;
            end else if (step == -1 && m_ratio > RMN) begin
                m_ratio--; m_pulse = 1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (valid) begin
            chk("x_real_world", int'(xrw), XP);
            chk("y_real_world", int'(yrw), YP);
            chk("ratio_n", int'(ratio), m_ratio);
            chk("z_real_world", int'(zrw), m_z);
            chk("step_pulse", int'(pulse), m_pulse);
            chk("x_light", int'(xl), m_x);
            chk("y_light", int'(yl), m_y);
            chk("pan_addr", int'(pan), m_pan);
            chk("tilt_addr", int'(tilt), m_tilt);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int npulse;

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    initial begin
        reset = 1'b1; up = 1'b0; dn = 1'b0; we = 1'b0;
        cidx = '0; cx = '0; cy = '0; cpan = '0; ctilt = '0; ridx = '0;
        tick();
        tick();
        chk("rst ratio", int'(ratio), 400);
        chk("rst z", int'(zrw), 800);
        chk("rst pan0", int'(pan), 1);
        chk("rst tilt0", int'(tilt), 2);
        chk("rst pulse", int'(pulse), 0);
        reset = 1'b0;
        ridx  = 3'd3;
        tick();
        chk("rd3 pan", int'(pan), 7);
        chk("rd3 tilt", int'(tilt), 8);
        ridx = 3'd0;

        // Tap up for 3 cycles: a single step
        up = 1'b1;
        tick();
        chk("tap ratio", int'(ratio), 401);
        chk("tap pulse", int'(pulse), 1);
        tick();
        chk("tap z", int'(zrw), 802);
        chk("tap pulse off", int'(pulse), 0);
        tick();
        up = 1'b0;
        tick();
        tick();
        chk("tap final", int'(ratio), 401);

        // Both pressed from idle, then up with down added while held
        do_reset();
        up = 1'b1; dn = 1'b1;
        repeat (5) tick();
        chk("both idle", int'(ratio), 400);
        dn = 1'b0;
        tick();
        tick();
        tick();
        dn = 1'b1;
        repeat (12) tick();
        up = 1'b0; dn = 1'b0;
        tick();
        chk("both in hold", int'(ratio), 401);

        // Direction swap: drop to idle, fresh press on the next cycle
        up = 1'b1;
        tick();
        tick();
        up = 1'b0; dn = 1'b1;
        tick();
        chk("swap drop", int'(ratio), 402);
        tick();
        chk("swap fresh", int'(ratio), 401);
        dn = 1'b0;
        tick();

        // Hold down for 20 cycles: steps at 0, 8, 12, 16
        do_reset();
        dn = 1'b1;
        npulse = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pulse) npulse++;
        end
        dn = 1'b0;
        repeat (10) begin
            tick();
            if (pulse) npulse++;
        end
        chk("hold dn ratio", int'(ratio), 396);
        chk("hold dn pulses", npulse, 4);

        // Reset while in repeat, button still held afterwards
        do_reset();
        dn = 1'b1;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("post-rst press", int'(ratio), 399);
        chk("post-rst pulse", int'(pulse), 1);
        dn = 1'b0;
        tick();

        // Climb to 1022, then saturate at 1023
        do_reset();
        up = 1'b1;
        repeat (2489) tick();
        up = 1'b0;
        tick();
        chk("preload ratio", int'(ratio), 1022);
        chk("preload z", int'(zrw), 2044);
        up = 1'b1;
        npulse = 0;
        repeat (20) begin
            tick();
            if (pulse) npulse++;
        end
        up = 1'b0;
        tick();
        chk("sat ratio", int'(ratio), 1023);
        chk("sat z", int'(zrw), 2046);
        chk("sat pulses", npulse, 1);

        // Table write with simultaneous read of the same entry
        ridx = 3'd2;
        we = 1'b1; cidx = 3'd2; cx = 11'd500; cy = 10'd200; cpan = 9'd17; ctilt = 9'd18;
        tick();
        chk("wr old x", int'(xl), 380);
        chk("wr old pan", int'(pan), 5);
        we = 1'b0;
        tick();
        chk("wr new x", int'(xl), 500);
        chk("wr new y", int'(yl), 200);
        chk("wr new pan", int'(pan), 17);
        chk("wr new tilt", int'(tilt), 18);

        // Out-of-range write ignored; must not alias onto entry 1
        we = 1'b1; cidx = 3'd5; cx = 11'd999; cy = 10'd999; cpan = 9'd300; ctilt = 9'd301;
        ridx = 3'd1;
        tick();
        we = 1'b0;
        tick();
        chk("oob wr x1", int'(xl), 380);
        chk("oob wr pan1", int'(pan), 3);
        chk("oob wr tilt1", int'(tilt), 4);
        ridx = 3'd5;
        tick();
        chk("oob rd x", int'(xl), 0);
        chk("oob rd pan", int'(pan), 0);
        ridx = 3'd4;
        tick();
        chk("oob rd tilt", int'(tilt), 0);
        ridx = 3'd3;
        tick();
        chk("rd3 x", int'(xl), 380);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
